fp_wb_arbiter: RTL

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

---
 rtl/fp_wb_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fp_wb_arbiter.sv
// FP regfile write-port arbiter: FLW has priority, FPU results go through a 2-deep FIFO, and a pending-register scoreboard tracks outstanding FPU ops.
// Latency: one cycle to the registered write port. Backpressure: fpu_ready is low while the FIFO is full and depends only on the registered count.
module fp_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_wen,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_rd,
    input  logic [31:0] fpu_data,
    output logic        fpu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rs3,
    input  logic [4:0]  rd_chk,
    output logic        hazard,
    output logic        fpregwen,
    output logic [4:0]  fp_wa,
    output logic [31:0] fp_wd,
    output logic [31:0] pending
);

    logic [1:0]  r_count;
    logic [4:0]  r_q_rd   [0:1];
    logic [31:0] r_q_data [0:1];
    logic [31:0] r_pending;

    logic        w_accept;
    logic        w_sel_vld;
    logic        w_fpu_sel;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_data;
    logic [1:0]  w_widx;
    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_pending_nxt;

    assign fpu_ready = (r_count < 2'd2);
    assign w_accept  = fpu_valid & fpu_ready;

    // Bypass only when the FIFO is empty so FPU results stay in order.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_fpu_sel  = 1'b0;
        w_pop      = 1'b0;
        w_bypass   = 1'b0;
        w_sel_rd   = mem_rd;
        w_sel_data = mem_data;
        if (mem_wen) begin
            w_sel_vld = 1'b1;
        end else if (r_count != 2'd0) begin
            w_sel_vld  = 1'b1;
            w_fpu_sel  = 1'b1;
            w_pop      = 1'b1;
            w_sel_rd   = r_q_rd[0];
            w_sel_data = r_q_data[0];
        end else if (w_accept) begin
            w_sel_vld  = 1'b1;
            w_fpu_sel  = 1'b1;
            w_bypass   = 1'b1;
            w_sel_rd   = fpu_rd;
            w_sel_data = fpu_data;
        end
    end

    assign w_push = w_accept & ~w_bypass;
    assign w_widx = r_count - {1'b0, w_pop};

    // Set is OR-ed in after the clear so a same-cycle issue keeps the bit.
    assign w_clr         = w_fpu_sel ? (32'd1 << w_sel_rd) : 32'd0;
    assign w_set         = iss_valid ? (32'd1 << iss_rd) : 32'd0;
    assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

    // Storage needs no reset: entries beyond r_count are never read.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_q_rd[0]   <= r_q_rd[1];
            r_q_data[0] <= r_q_data[1];
        end
        if (w_push) begin
            r_q_rd[w_widx[0]]   <= fpu_rd;
            r_q_data[w_widx[0]] <= fpu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_pending <= 32'd0;
            fpregwen  <= 1'b0;
            fp_wa     <= 5'd0;
            fp_wd     <= 32'd0;
        end else begin
            r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_pending <= w_pending_nxt;
            fpregwen  <= w_sel_vld;
            if (w_sel_vld) begin
                fp_wa <= w_sel_rd;
                fp_wd <= w_sel_data;
            end
        end
    end

    assign pending = r_pending;
    assign hazard  = r_pending[rs1] | r_pending[rs2] | r_pending[rs3] | r_pending[rd_chk];

endmodule
